// File: rtl/debounce_arbiter_if.sv
// Button/debounce bundle between the board-facing debouncer and the user logic.
// The slave side is the debouncer; the master side drives raw levels and consumes the results.
interface debounce_arbiter_if #(
    parameter int N_CH  = 4,
    parameter int GID_W = $clog2(N_CH)
);
    logic [N_CH-1:0]  btn_raw;
    logic [N_CH-1:0]  btn_stable;
    logic [N_CH-1:0]  press;
    logic [N_CH-1:0]  release_pulse;
    logic             busy;
    logic [GID_W-1:0] grant_id;

    modport master (
        output btn_raw,
        input  btn_stable, press, release_pulse, busy, grant_id
    );

    modport slave (
        input  btn_raw,
        output btn_stable, press, release_pulse, busy, grant_id
    );
endinterface

// File: rtl/debounce_arbiter.sv
// Debounces N_CH buttons with one shared countdown timer handed out round-robin.
// A channel's stable level flips only after a full bounce-free interval while it owns the timer.
module debounce_arbiter #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter int GID_W           = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    debounce_arbiter_if.slave bus
);

    typedef enum logic {IDLE, TIMING} state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GID_W-1:0] RR_INIT  = GID_W'(N_CH - 1);

    state_t           state_q, state_d;
    logic [N_CH-1:0]  sync1_q, sync2_q;
    logic [N_CH-1:0]  stable_q, stable_d;
    logic [N_CH-1:0]  press_q, press_d;
    logic [N_CH-1:0]  release_q, release_d;
    logic             busy_q, busy_d;
    logic [GID_W-1:0] grant_q, grant_d;
    logic [GID_W-1:0] rr_last_q, rr_last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_CH-1:0]  req;
    logic [GID_W-1:0] rr_idx;
    logic [GID_W-1:0] sel;
    logic             sel_valid;

    assign req = sync2_q ^ stable_q;

    // Search starts just after the last winner, so a channel that just aborted goes to the back.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        rr_idx    = '0;
        for (int i = 1; i <= N_CH; i++) begin
            rr_idx = GID_W'((int'(rr_last_q) + i) % N_CH);
            if (!sel_valid && req[rr_idx]) begin
                sel_valid = 1'b1;
                sel       = rr_idx;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        stable_d  = stable_q;
        press_d   = '0;
        release_d = '0;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    grant_d   = sel;
                    rr_last_d = sel;
                    cnt_d     = CNT_LOAD;
                    state_d   = TIMING;
                end
            end
            TIMING: begin
                if (sync2_q[grant_q] == stable_q[grant_q]) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    stable_d[grant_q] = ~stable_q[grant_q];
                    if (stable_d[grant_q]) begin
                        press_d[grant_q] = 1'b1;
                    end else begin
                        release_d[grant_q] = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == TIMING);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            busy_q    <= 1'b0;
            grant_q   <= '0;
            rr_last_q <= RR_INIT;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= bus.btn_raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.btn_stable    = stable_q;
    assign bus.press         = press_q;
    assign bus.release_pulse = release_q;
    assign bus.busy          = busy_q;
    assign bus.grant_id      = grant_q;

endmodule

// File: tb/tb_debounce_arbiter.sv
// Directed bench for debounce_arbiter: expected pulses are queued when stimulus is driven
// and matched against every press/release pulse the design emits.
module tb_debounce_arbiter;

    localparam int N_CH = 4;
    localparam int DC   = 20;

    typedef struct {
        int ch;
        bit is_press;
        int edge_n;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   t0  = 0;
    int   checks   = 0;
    int   failures = 0;
    ev_t  exp_q[$];

    logic [2*N_CH-1:0] obs_v;
    logic [2*N_CH-1:0] exp_v;
    ev_t               ev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debounce_arbiter_if #(.N_CH(N_CH)) bus ();

    debounce_arbiter #(
        .N_CH(N_CH),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Edge n of a scenario is the n-th clock edge after reset release.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.btn_raw = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t0 = cyc;
    endtask

    task automatic goto(input int n);
        while (cyc < t0 + n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int ch, input bit is_press, input int n);
        ev_t e;
        e.ch = ch;
        e.is_press = is_press;
        e.edge_n = t0 + n;
        exp_q.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stable"}, 32'(bus.btn_stable), 0);
        check({tag, "_pulses"}, 32'({bus.press, bus.release_pulse}), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_grant"}, 32'(bus.grant_id), 0);
    endtask

    task automatic check_busy_grant(input string tag, input bit busy, input int gid);
        check({tag, "_busy"}, 32'(bus.busy), 32'(busy));
        if (busy) check({tag, "_grant"}, 32'(bus.grant_id), 32'(gid));
    endtask

    // Pulse monitor: every pulse must match the head of the scoreboard exactly.
    always @(negedge clk) begin
        obs_v = {bus.press, bus.release_pulse};
        if (obs_v != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(obs_v), 0);
            end else begin
                ev = exp_q.pop_front();
                exp_v = '0;
                if (ev.is_press) exp_v[N_CH + ev.ch] = 1'b1;
                else             exp_v[ev.ch] = 1'b1;
                check($sformatf("pulse_vec_ch%0d", ev.ch), 32'(obs_v), 32'(exp_v));
                check($sformatf("pulse_edge_ch%0d", ev.ch), 32'(cyc), 32'(ev.edge_n));
                check($sformatf("pulse_level_ch%0d", ev.ch), 32'(bus.btn_stable[ev.ch]),
                      32'(ev.is_press));
            end
        end
    end

    initial begin
        bus.btn_raw = '0;

        // Clean press on channel 0.
        do_reset();
        check_zero("s1_reset");
        expect_pulse(0, 1'b1, 32);
        goto(9);  bus.btn_raw[0] = 1'b1;
        goto(11); check_busy_grant("s1_e11", 1'b0, 0);
        goto(12); check_busy_grant("s1_e12", 1'b1, 0);
        goto(31); check("s1_e31_stable", 32'(bus.btn_stable), 32'h0);
        goto(32); check("s1_e32_stable", 32'(bus.btn_stable), 32'h1);
                  check("s1_e32_busy", 32'(bus.busy), 0);
        goto(40); check("s1_drained", 32'(exp_q.size()), 0);

        // Bounce on channel 1: abort then re-grant.
        do_reset();
        expect_pulse(1, 1'b1, 38);
        goto(9);  bus.btn_raw[1] = 1'b1;
        goto(14); bus.btn_raw[1] = 1'b0;
        goto(15); bus.btn_raw[1] = 1'b1;
        goto(16); check_busy_grant("s2_e16", 1'b1, 1);
        goto(17); check_busy_grant("s2_e17", 1'b0, 0);
        goto(18); check_busy_grant("s2_e18", 1'b1, 1);
        goto(37); check("s2_e37_stable", 32'(bus.btn_stable), 32'h0);
        goto(38); check("s2_e38_stable", 32'(bus.btn_stable), 32'h2);
        goto(45); check("s2_drained", 32'(exp_q.size()), 0);

        // Contention between channels 0 and 2.
        do_reset();
        expect_pulse(0, 1'b1, 32);
        expect_pulse(2, 1'b1, 53);
        goto(9);  bus.btn_raw = 4'b0101;
        goto(12); check_busy_grant("s3_e12", 1'b1, 0);
        goto(32); check("s3_e32_stable", 32'(bus.btn_stable), 32'h1);
                  check("s3_e32_busy", 32'(bus.busy), 0);
        goto(33); check_busy_grant("s3_e33", 1'b1, 2);
        goto(53); check("s3_e53_stable", 32'(bus.btn_stable), 32'h5);
        goto(60); check("s3_drained", 32'(exp_q.size()), 0);

        // Round-robin: ch3 held, ch0+ch2 pressed, then ch0+ch3 released with rr_last=2.
        do_reset();
        expect_pulse(3, 1'b1, 32);
        expect_pulse(0, 1'b1, 62);
        expect_pulse(2, 1'b1, 83);
        expect_pulse(3, 1'b0, 112);
        expect_pulse(0, 1'b0, 133);
        goto(9);   bus.btn_raw = 4'b1000;
        goto(39);  bus.btn_raw = 4'b1101;
        goto(42);  check_busy_grant("s4_e42", 1'b1, 0);
        goto(63);  check_busy_grant("s4_e63", 1'b1, 2);
        goto(89);  bus.btn_raw = 4'b0100;
        goto(92);  check_busy_grant("s4_e92", 1'b1, 3);
        goto(113); check_busy_grant("s4_e113", 1'b1, 0);
        goto(133); check("s4_e133_stable", 32'(bus.btn_stable), 32'h4);
        goto(140); check("s4_drained", 32'(exp_q.size()), 0);

        // Five-cycle glitch on channel 2: granted then abandoned.
        do_reset();
        goto(9);  bus.btn_raw[2] = 1'b1;
        goto(12); check_busy_grant("s5_e12", 1'b1, 2);
        goto(14); bus.btn_raw[2] = 1'b0;
        goto(16); check_busy_grant("s5_e16", 1'b1, 2);
        goto(17); check_busy_grant("s5_e17", 1'b0, 0);
        goto(18); check_busy_grant("s5_e18", 1'b0, 0);
        goto(60); check("s5_stable", 32'(bus.btn_stable), 32'h0);
                  check("s5_drained", 32'(exp_q.size()), 0);

        // Reset in the middle of channel 0's interval with the button still held.
        do_reset();
        expect_pulse(0, 1'b1, 43);
        goto(9);  bus.btn_raw[0] = 1'b1;
        goto(15); check_busy_grant("s6_e15", 1'b1, 0);
        goto(19); rst = 1'b1;
        goto(20); rst = 1'b0;
                  check_zero("s6_e20");
        goto(22); check_busy_grant("s6_e22", 1'b0, 0);
        goto(23); check_busy_grant("s6_e23", 1'b1, 0);
        goto(42); check("s6_e42_stable", 32'(bus.btn_stable), 32'h0);
        goto(43); check("s6_e43_stable", 32'(bus.btn_stable), 32'h1);
        goto(50); check("s6_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debounce_arbiter.md
Name: debounce_arbiter

Overview:
- Debounces N_CH raw push-button inputs using one shared countdown timer instead of one timer per button.
- Each channel has its own 2-flop synchronizer and stable-state register. A channel requests the timer when its synchronized input differs from its stable state.
- A round-robin arbiter grants the timer to one channel at a time. A grant toggles the channel's stable state only after a full bounce-free interval.
- Sits between the board buttons and the user logic, replacing per-button debouncer instances.

Parameters:
- N_CH, 4: number of button channels (2..16).
- DEBOUNCE_CYCLES, 20: required bounce-free interval in clk cycles (>= 2).
- CNT_W, $clog2(DEBOUNCE_CYCLES): timer width.
- GID_W, $clog2(N_CH): grant index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  N_CH  asynchronous raw button levels.
- btn_stable  out  N_CH  debounced levels.
- press  out  N_CH  one-cycle pulse when btn_stable[i] goes 0->1.
- release  out  N_CH  one-cycle pulse when btn_stable[i] goes 1->0.
- busy  out  1  high while state is TIMING.
- grant_id  out  GID_W  channel currently owning the timer; valid when busy.

Behaviour:
- Reset (rst high at an edge), all values take effect at that edge:
  - sync flops, btn_stable, press, release, busy, grant_id, cnt all become 0.
  - state becomes IDLE; rr_last becomes N_CH-1, so channel 0 has first priority.
  - Reset during TIMING abandons the interval. No pulse is produced for it.
- Synchronizer: sync1 <= btn_raw; sync2 <= sync1. Only sync2 is used internally.
- Request vector: req = sync2 ^ btn_stable (combinational).
- IDLE state:
  - If req != 0, select the first set req bit searching rr_last+1, rr_last+2, ... modulo N_CH.
  - On selection: grant_id <= sel, rr_last <= sel, cnt <= DEBOUNCE_CYCLES-1, state <= TIMING.
  - If req == 0, remain in IDLE.
- TIMING state, evaluated every edge using g = grant_id, in this priority order:
  1. If sync2[g] == btn_stable[g] (bounce back): abort, state <= IDLE, no output change. rr_last keeps g, so other requesters get priority next.
  2. Else if cnt == 0: btn_stable[g] <= ~btn_stable[g]. press[g] <= 1 if the new value is 1; release[g] <= 1 if the new value is 0. state <= IDLE.
  3. Else: cnt <= cnt-1.
- press and release are registered and high for exactly one cycle. At most one bit across both vectors is high in any cycle.
- busy is registered (busy == (state == TIMING)). grant_id holds its last value in IDLE.
- Latency, uncontended channel:
  - raw level sampled into sync1 at edge E.
  - Grant issued at E+2.
  - btn_stable changes and the pulse asserts at edge E+2+DEBOUNCE_CYCLES.
- Contention: requesting channels that are not granted wait. Their requests persist as long as sync2 still differs from btn_stable.
- IDLE always lasts at least one cycle between grants.
  - Worst-case wait for a channel with a sustained request is (N_CH-1)*(DEBOUNCE_CYCLES+1) cycles.
- Level changes on non-granted channels during TIMING are only tracked by their synchronizers. Their stable state is unaffected.
- A raw level held through reset is re-debounced from stable=0 after reset. A held button therefore yields one press pulse.

Test Plan:
All scenarios use N_CH=4 and DEBOUNCE_CYCLES=20; edge numbers count from reset release.
1. Clean press: btn_raw[0] 0->1 captured at edge 10 and held.
   -> grant_id=0 and busy=1 from edge 12; btn_stable[0]=1 and press[0]=1 at edge 32 only; busy=0 at edge 32.
2. Bounce: btn_raw[1] high at 10, low at 15, high at 16 sustained.
   -> abort at edge 17, re-grant at 18; btn_stable[1]=1 and press[1] at edge 38; no pulse before.
3. Contention: btn_raw[0] and btn_raw[2] high at edge 10.
   -> ch0 stable at 32; ch2 granted at 33, stable with press[2] at 53.
4. Round-robin: after scenario 3 (rr_last=2), btn_raw[0] and btn_raw[3] both release together.
   -> ch3 served first (release[3]), ch0 second; exactly one pulse each.
5. Short glitch: btn_raw[2] high for 5 cycles only.
   -> grant then abort; btn_stable[2] stays 0; no press or release pulse.
6. Mid-operation reset: rst high at edge 20 during scenario 1's TIMING, btn_raw[0] still high.
   -> all outputs 0 at edge 20; re-debounce gives btn_stable[0]=1 and press[0] at edge 20+1+2+20 (edge 43).
